keypad_scan: RTL
================

Name: keypad_scan

Overview:
- Upstream front end for the meter core: scans a 4x4 active-low matrix keypad, debounces presses and releases, and produces the 4-bit key code ReadFromKeyBoard plus the NoShut level strobe.
- NoShut is high when no key is held and low while a debounced key is held.
- The core treats a 1->0 transition of NoShut as one keypress and samples ReadFromKeyBoard on that edge. It also measures long-press duration from how long NoShut stays low.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven before its rows are sampled. Must be >= 4.
- DEBOUNCE, 20000: consecutive identical synchronized samples required to accept a press or a release. Must be >= 2.

Ports:
- CLK  input  1  system clock.
- RST  input  1  synchronous, active-high reset.
- Row  input  4  keypad rows, active-low (pulled up externally), asynchronous to CLK.
- Col  output 4  column drive, active-low, exactly one bit low at all times.
- ReadFromKeyBoard  output 4  code of the last accepted key.
- NoShut  output 1  1 = no key held, 0 = debounced key held.

Behaviour:
- Clock and reset: single clock CLK. Reset RST is synchronous and active-high.
- Reset values: Col=4'b1110 (column 0), NoShut=1, ReadFromKeyBoard=4'd15, FSM in SCAN, all counters 0, synchronizer flops 4'b1111. Reset mid-press drops NoShut to 1 at that edge. The key must then be fully re-debounced.
- Row synchronization: Row passes through a 2-flop synchronizer (RowS). All decisions use RowS only.
- Key map (row r, column c → code):
  - r0: 1, 2, 3, 10
  - r1: 4, 5, 6, 11
  - r2: 7, 8, 9, 12
  - r3: 14, 0, 15, 13
  - The core uses 11 = start, 12 = clear, 13 = confirm, 0-9 = digits.
- A column sample is "single" when exactly one RowS bit is 0. Zero or two or more low bits count as no key (ghost/multi-press rejection).
- SCAN state:
  - Slot counter runs 0..SCAN_DIV-1 while one column is driven. RowS is sampled at count SCAN_DIV-1.
  - No single key at the sample: advance the column 0→1→2→3→0 (Col 1110→1101→1011→0111→1110) and clear the counter.
  - Single key at the sample: latch row index and column, clear the debounce counter, go to PRESS_DB. Col stays frozen.
- PRESS_DB state:
  - Each cycle, compare RowS to the latched pattern.
  - Match: increment the counter.
  - Mismatch: return to SCAN on the next column with NoShut still 1 (bounce rejected).
  - When the counter reaches DEBOUNCE-1: in the same edge, set ReadFromKeyBoard to the mapped code and NoShut to 0, then go to HELD. Code and NoShut therefore change together, and the code is valid on the first cycle NoShut is 0.
- HELD state:
  - Col stays frozen. NoShut stays 0 and ReadFromKeyBoard is stable for as long as the key is held.
  - RowS all-ones clears the counter and goes to REL_DB.
  - Any other pattern stays in HELD. Presses of other keys are ignored, so no rollover is produced.
- REL_DB state:
  - RowS all-ones for DEBOUNCE consecutive cycles: set NoShut to 1, keep ReadFromKeyBoard at its last value, go to SCAN on the next column.
  - Any low bit before then: return to HELD with NoShut still 0 (release bounce rejected).
- Press latency: from a clean stable press to the NoShut fall is at most 4*SCAN_DIV + DEBOUNCE + 2 cycles.
- Release latency: from a clean release to the NoShut rise is DEBOUNCE + 2..3 cycles.
- Event rule: exactly one NoShut falling edge per physical press, regardless of bounce or hold duration.
- Counter widths are sized from the parameters (clog2). Counters saturate or are cleared and never wrap inside a state.

Test Plan (SCAN_DIV=4, DEBOUNCE=8):
1. Reset, no key → Col cycles 1110, 1101, 1011, 0111 every 4 cycles; NoShut=1; ReadFromKeyBoard=15.
2. Hold key at r1,c3 (Row=1101 while Col=0111) → NoShut falls with ReadFromKeyBoard=11 within 4*4+8+2 cycles, and stays 0 while held. Release → NoShut=1 about 10 cycles later; ReadFromKeyBoard stays 11.
3. Press r3,c1 with 3 bounces of 2 cycles each, then stable → exactly one NoShut fall with code 0. Release with 2-cycle bounces → exactly one rise.
4. Press r0,c0 and r1,c0 together (column 0 Row=1100) → rejected, NoShut stays 1. Release r1, keep r0 → code 1 accepted.
5. Hold r2,c2 (code 9), then also press r0,c1 → code stays 9, no extra NoShut fall. Release r2,c2 while r0,c1 is still held → NoShut rises, then a new fall with code 2.
6. Assert RST for 1 cycle while a key is in HELD → NoShut=1 and Col=1110 at that edge. Continued hold → fresh debounced press reported after the scan reaches that column.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner with press/release debounce.
// Produces the accepted key code and the NoShut held-key level (low while a key is held).
module keypad_scan #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 20000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] Row,
    output logic [3:0] Col,
    output logic [3:0] ReadFromKeyBoard,
    output logic       NoShut
);

    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;

    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] PRESS_LAST = DW'(DEBOUNCE - 2);
    localparam logic [DW-1:0] REL_LAST   = DW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    row_meta_q;
    logic [3:0]    row_s_q;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [3:0]    pat_q, pat_d;
    logic [3:0]    code_q, code_d;
    logic          noshut_q, noshut_d;

    function automatic logic is_single(input logic [3:0] rows);
        case (rows)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: is_single = 1'b1;
            default:                            is_single = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] row_index(input logic [3:0] rows);
        case (rows)
            4'b1101: row_index = 2'd1;
            4'b1011: row_index = 2'd2;
            4'b0111: row_index = 2'd3;
            default: row_index = 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'b00_00: key_code = 4'd1;
            4'b00_01: key_code = 4'd2;
            4'b00_10: key_code = 4'd3;
            4'b00_11: key_code = 4'd10;
            4'b01_00: key_code = 4'd4;
            4'b01_01: key_code = 4'd5;
            4'b01_10: key_code = 4'd6;
            4'b01_11: key_code = 4'd11;
            4'b10_00: key_code = 4'd7;
            4'b10_01: key_code = 4'd8;
            4'b10_10: key_code = 4'd9;
            4'b10_11: key_code = 4'd12;
            4'b11_00: key_code = 4'd14;
            4'b11_01: key_code = 4'd0;
            4'b11_10: key_code = 4'd15;
            default:  key_code = 4'd13;
        endcase
    endfunction

    // Two-flop synchronizer; every decision below looks only at row_s_q.
    always_ff @(posedge CLK) begin
        if (RST) begin
            row_meta_q <= 4'b1111;
            row_s_q    <= 4'b1111;
        end else begin
            row_meta_q <= Row;
            row_s_q    <= row_meta_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= SCAN;
            col_idx_q  <= 2'd0;
            scan_cnt_q <= '0;
            deb_cnt_q  <= '0;
            pat_q      <= 4'b1111;
            code_q     <= 4'd15;
            noshut_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            col_idx_q  <= col_idx_d;
            scan_cnt_q <= scan_cnt_d;
            deb_cnt_q  <= deb_cnt_d;
            pat_q      <= pat_d;
            code_q     <= code_d;
            noshut_q   <= noshut_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        col_idx_d  = col_idx_q;
        scan_cnt_d = scan_cnt_q;
        deb_cnt_d  = deb_cnt_q;
        pat_d      = pat_q;
        code_d     = code_q;
        noshut_d   = noshut_q;

        case (state_q)
            SCAN: begin
                if (scan_cnt_q == SCAN_LAST) begin
                    scan_cnt_d = '0;
                    if (is_single(row_s_q)) begin
                        pat_d     = row_s_q;
                        deb_cnt_d = '0;
                        state_d   = PRESS_DB;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    scan_cnt_d = scan_cnt_q + 1'b1;
                end
            end
            PRESS_DB: begin
                // The SCAN sample counts as the first of the DEBOUNCE matching samples.
                if (row_s_q == pat_q) begin
                    if (deb_cnt_q == PRESS_LAST) begin
                        code_d    = key_code(row_index(pat_q), col_idx_q);
                        noshut_d  = 1'b0;
                        deb_cnt_d = '0;
                        state_d   = HELD;
                    end else begin
                        deb_cnt_d = deb_cnt_q + 1'b1;
                    end
                end else begin
                    state_d    = SCAN;
                    col_idx_d  = col_idx_q + 2'd1;
                    scan_cnt_d = '0;
                end
            end
            HELD: begin
                if (row_s_q == 4'b1111) begin
                    deb_cnt_d = '0;
                    state_d   = REL_DB;
                end
            end
            REL_DB: begin
                if (row_s_q == 4'b1111) begin
                    if (deb_cnt_q == REL_LAST) begin
                        noshut_d   = 1'b1;
                        state_d    = SCAN;
                        col_idx_d  = col_idx_q + 2'd1;
                        scan_cnt_d = '0;
                    end else begin
                        deb_cnt_d = deb_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = HELD;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    assign Col              = ~(4'b0001 << col_idx_q);
    assign ReadFromKeyBoard = code_q;
    assign NoShut           = noshut_q;

endmodule
